// File: rtl/trap_ctrl_unit_pkg.sv
// trap_ctrl_unit_pkg: CSR addresses, interrupt codes and FSM states for the trap control unit.
package trap_ctrl_unit_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [3:0]  IRQ_SW      = 4'd3;
    localparam logic [3:0]  IRQ_TM      = 4'd7;
    localparam logic [3:0]  IRQ_EXT     = 4'd11;
    localparam int          CAUSE_ECALL = 11;
    typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;
endpackage

// File: rtl/trap_ctrl_unit_irq_arb.sv
// trap_irq_arb: fixed-priority interrupt selection, ext > sw > tm, gated by mstatus.MIE.
module trap_irq_arb
    import trap_ctrl_unit_pkg::*;
(
    input  logic       mie,
    input  logic [2:0] pend,
    output logic       take,
    output logic [3:0] code
);
    // pend is ordered {ext, tm, sw}, matching mip bits 11/7/3
    always_comb begin
        take = mie && |pend;
        code = pend[2] ? IRQ_EXT : pend[0] ? IRQ_SW : pend[1] ? IRQ_TM : 4'd0;
    end
endmodule

// File: rtl/trap_ctrl_unit.sv
// trap_ctrl_unit: machine trap CSRs plus ecall/mret/interrupt sequencing over a flush/redirect handshake.
// Define TCU_VECTORED_EN to enable vectored interrupt dispatch (mtvec[1:0]==1).
module trap_ctrl_unit
    import trap_ctrl_unit_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = 'h8000_0000,
    parameter int              ECALL_CAUSE = CAUSE_ECALL
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            irq_sw_i,
    input  logic            irq_tm_i,
    input  logic            irq_ext_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic            flush_ack_i,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            trap_busy_o,
    output logic            mie_o
);
    localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state;
    logic            mpie, take, commit, do_ecall, do_irq, do_mret, accept;
    logic [2:0]      mie_en;
    logic [3:0]      code;
    logic [XLEN-1:0] mtvec, mepc, mcause, target, base, irq_pc, next_target, trap_pc, mtvec_w;

    trap_irq_arb u_arb (
        .mie  (mie_o),
        .pend ({irq_ext_i & mie_en[2], irq_tm_i & mie_en[1], irq_sw_i & mie_en[0]}),
        .take (take),
        .code (code)
    );

    // ecall outranks interrupts, which outrank mret; one event per commit
    assign commit      = commit_valid_i && state == IDLE;
    assign do_ecall    = commit && ecall_i;
    assign do_irq      = commit && !ecall_i && take;
    assign do_mret     = commit && !ecall_i && !take && mret_i;
    assign accept      = do_ecall || do_irq || do_mret;
    assign trap_busy_o = state != IDLE;
    assign base        = mtvec & ALIGN;
    assign trap_pc     = do_ecall ? exc_pc_i : next_pc_i;
`ifdef TCU_VECTORED_EN
    assign irq_pc  = mtvec[1:0] == 2'd1 ? base + XLEN'({code, 2'b00}) : base;
    assign mtvec_w = (csr_wdata_i & ALIGN) | XLEN'(csr_wdata_i[1:0] == 2'd1);
`else
    assign irq_pc  = base;
    assign mtvec_w = csr_wdata_i & ALIGN;
`endif
    assign next_target = do_ecall ? base : do_irq ? irq_pc : mepc;

    always_comb begin
        csr_rdata_o = csr_addr_i == CSR_MSTATUS ? XLEN'({mpie, 3'b000, mie_o, 3'b000}) :
                      csr_addr_i == CSR_MIE     ? XLEN'({mie_en[2], 3'b000, mie_en[1], 3'b000, mie_en[0], 3'b000}) :
                      csr_addr_i == CSR_MTVEC   ? mtvec :
                      csr_addr_i == CSR_MEPC    ? mepc :
                      csr_addr_i == CSR_MCAUSE  ? mcause :
                      csr_addr_i == CSR_MIP     ? XLEN'({irq_ext_i, 3'b000, irq_tm_i, 3'b000, irq_sw_i, 3'b000}) :
                      '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            mie_o            <= 1'b0;
            mpie             <= 1'b0;
            mie_en           <= '0;
            mtvec            <= MTVEC_RESET & ALIGN;
            mepc             <= '0;
            mcause           <= '0;
            target           <= '0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            if (csr_we_i && csr_addr_i == CSR_MIE)
                mie_en <= {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
            if (csr_we_i && csr_addr_i == CSR_MTVEC)
                mtvec <= mtvec_w;
            // a trap in the same cycle overrides software writes to mstatus/mepc/mcause
            if (do_ecall || do_irq) begin
                mepc   <= trap_pc & ALIGN;
                mcause <= do_ecall ? XLEN'(ECALL_CAUSE) : {1'b1, {(XLEN-5){1'b0}}, code};
                mpie   <= mie_o;
                mie_o  <= 1'b0;
            end else if (do_mret) begin
                mie_o <= mpie;
                mpie  <= 1'b1;
            end else if (csr_we_i) begin
                if (csr_addr_i == CSR_MSTATUS) begin
                    mie_o <= csr_wdata_i[3];
                    mpie  <= csr_wdata_i[7];
                end
                if (csr_addr_i == CSR_MEPC)
                    mepc <= csr_wdata_i & ALIGN;
                if (csr_addr_i == CSR_MCAUSE)
                    mcause <= csr_wdata_i;
            end
            case (state)
                IDLE: if (accept) begin
                    state   <= FLUSH;
                    flush_o <= 1'b1;
                    target  <= next_target;
                end
                FLUSH: if (flush_ack_i) begin
                    state            <= REDIR;
                    flush_o          <= 1'b0;
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= target;
                end
                default: begin
                    state            <= IDLE;
                    redirect_valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl_unit.sv
// tb_trap_ctrl_unit: random and directed trap sequences checked against a behavioural CSR/priority model.
module tb_trap_ctrl_unit;
`ifdef TCU_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        commit_valid_i = 0, ecall_i = 0, mret_i = 0;
    logic [63:0] exc_pc_i = 0, next_pc_i = 0, csr_wdata_i = 0;
    logic        irq_sw_i = 0, irq_tm_i = 0, irq_ext_i = 0, csr_we_i = 0, flush_ack_i = 0;
    logic [11:0] csr_addr_i = 0;
    logic [63:0] csr_rdata_o, redirect_pc_o;
    logic        flush_o, redirect_valid_o, trap_busy_o, mie_o;

    trap_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .commit_valid_i(commit_valid_i), .ecall_i(ecall_i), .mret_i(mret_i),
        .exc_pc_i(exc_pc_i), .next_pc_i(next_pc_i), .irq_sw_i(irq_sw_i), .irq_tm_i(irq_tm_i),
        .irq_ext_i(irq_ext_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .flush_ack_i(flush_ack_i), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .trap_busy_o(trap_busy_o), .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [63:0] exp_q[$];
    bit          m_mie, m_mpie;
    logic [63:0] m_mie_reg, m_mtvec, m_mepc, m_mcause;
    logic [11:0] addrs[7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h123};

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every redirect pulse must match the oldest expected target
    always @(negedge clk) if (rst_n && redirect_valid_o) begin
        if (exp_q.size() == 0) check("redirect_unexpected", 64'd1, 64'd0);
        else check("redirect_pc", redirect_pc_o, exp_q.pop_front());
    end

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mepc = 0; m_mcause = 0; m_mtvec = 64'h8000_0000;
    endfunction

    function automatic void model_write(logic [11:0] a, logic [63:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h304: m_mie_reg = d & 64'h888;
            12'h305: m_mtvec = (d & ~64'd3) | ((VEC && d[1:0] == 2'd1) ? 64'd1 : 64'd0);
            12'h341: m_mepc = d & ~64'd3;
            12'h342: m_mcause = d;
            default: ;
        endcase
    endfunction

    function automatic logic [63:0] model_read(logic [11:0] a);
        case (a)
            12'h300: return (64'(m_mpie) << 7) | (64'(m_mie) << 3);
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (64'(irq_ext_i) << 11) | (64'(irq_tm_i) << 7) | (64'(irq_sw_i) << 3);
            default: return 64'd0;
        endcase
    endfunction

    function automatic int pick_irq();
        if (!m_mie) return 0;
        if (irq_ext_i && m_mie_reg[11]) return 11;
        if (irq_sw_i && m_mie_reg[3]) return 3;
        if (irq_tm_i && m_mie_reg[7]) return 7;
        return 0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic csr_write(logic [11:0] a, logic [63:0] d);
        csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        @(negedge clk);
        csr_we_i = 0;
        model_write(a, d);
    endtask

    task automatic csr_check(logic [11:0] a, string name);
        csr_addr_i = a;
        #1;
        check(name, csr_rdata_o, model_read(a));
    endtask

    task automatic commit(bit cv, bit e, bit m, logic [63:0] epc, logic [63:0] npc,
                          bit we, logic [11:0] a, logic [63:0] d, int dly);
        int code;
        bit acc;
        logic [63:0] tgt, base;
        commit_valid_i = cv; ecall_i = e; mret_i = m; exc_pc_i = epc; next_pc_i = npc;
        csr_we_i = we; csr_addr_i = a; csr_wdata_i = d; flush_ack_i = 1'($urandom_range(0, 1));
        code = pick_irq();
        base = m_mtvec & ~64'd3;
        acc = cv;
        tgt = 0;
        if (cv && e) begin
            tgt = base; m_mcause = 64'd11; m_mepc = epc & ~64'd3; m_mpie = m_mie; m_mie = 0;
        end else if (cv && code != 0) begin
            tgt = (VEC && m_mtvec[1:0] == 2'd1) ? base + 64'(4 * code) : base;
            m_mcause = {1'b1, 63'(code)}; m_mepc = npc & ~64'd3; m_mpie = m_mie; m_mie = 0;
        end else if (cv && m) begin
            tgt = m_mepc; m_mie = m_mpie; m_mpie = 1;
        end else acc = 0;
        if (we && !(acc && (a == 12'h300 || a == 12'h341 || a == 12'h342))) model_write(a, d);
        if (acc) exp_q.push_back(tgt);
        @(negedge clk);
        commit_valid_i = 0; ecall_i = 0; mret_i = 0; csr_we_i = 0; flush_ack_i = 0;
        if (!acc) begin
            check("no_flush", 64'(flush_o), 64'd0);
            check("idle_busy", 64'(trap_busy_o), 64'd0);
            return;
        end
        check("flush_set", 64'(flush_o), 64'd1);
        check("busy_set", 64'(trap_busy_o), 64'd1);
        check("mie_o", 64'(mie_o), 64'(m_mie));
        repeat (dly < 0 ? $urandom_range(0, 5) : dly) begin
            commit_valid_i = 1; ecall_i = 1'($urandom_range(0, 1)); mret_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("flush_hold", 64'(flush_o), 64'd1);
        end
        commit_valid_i = 0; ecall_i = 0; mret_i = 0; flush_ack_i = 1;
        @(negedge clk);
        flush_ack_i = 0;
        check("flush_drop", 64'(flush_o), 64'd0);
        check("redirect_valid", 64'(redirect_valid_o), 64'd1);
        @(negedge clk);
        check("redirect_pulse", 64'(redirect_valid_o), 64'd0);
        check("busy_clear", 64'(trap_busy_o), 64'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_flush", 64'(flush_o), 64'd0);
        check("rst_redirect", 64'(redirect_valid_o), 64'd0);
        check("rst_busy", 64'(trap_busy_o), 64'd0);
        check("rst_mie_o", 64'(mie_o), 64'd0);
        foreach (addrs[i]) csr_check(addrs[i], "rst_csr");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        // ecall into a non-reset mtvec
        csr_write(12'h305, 64'h8000_1000);
        commit(1, 1, 0, 64'h8000_0100, 64'h8000_0104, 0, 0, 0, 0);
        csr_check(12'h341, "t1_mepc");
        csr_check(12'h342, "t1_mcause");
        csr_check(12'h300, "t1_mstatus");
        // timer interrupt
        csr_write(12'h300, 64'h8);
        csr_write(12'h304, 64'h80);
        irq_tm_i = 1;
        commit(1, 0, 0, 64'h1fc, 64'h200, 0, 0, 0, -1);
        csr_check(12'h342, "t2_mcause");
        csr_check(12'h341, "t2_mepc");
        csr_check(12'h300, "t2_mstatus");
        // all three pending: ext first, then sw after mret
        csr_write(12'h300, 64'h8);
        csr_write(12'h304, 64'h888);
        irq_ext_i = 1; irq_sw_i = 1;
        commit(1, 0, 0, 64'h300, 64'h304, 0, 0, 0, -1);
        csr_check(12'h342, "t3_mcause_ext");
        irq_ext_i = 0;
        commit(1, 0, 1, 64'h400, 64'h404, 0, 0, 0, -1);
        commit(1, 0, 0, 64'h500, 64'h504, 0, 0, 0, -1);
        csr_check(12'h342, "t3_mcause_sw");
        irq_sw_i = 0; irq_tm_i = 0;
        // mret restoring MIE
        csr_write(12'h341, 64'h8000_0104);
        csr_write(12'h300, 64'h80);
        commit(1, 0, 1, 64'h600, 64'h604, 0, 0, 0, 1);
        csr_check(12'h300, "t4_mstatus");
        // MIE=0 masks a pending interrupt; slow ack with busy-time noise
        csr_write(12'h300, 64'h0);
        irq_tm_i = 1;
        commit(1, 0, 0, 64'h700, 64'h704, 0, 0, 0, -1);
        commit(1, 1, 0, 64'h800, 64'h804, 1, 12'h341, 64'h1234, 5);
        csr_check(12'h341, "t5_mepc_trap_wins");
        irq_tm_i = 0;
        // external interrupt through a vectored-mode mtvec
        csr_write(12'h305, 64'h8000_1001);
        csr_check(12'h305, "t6_mtvec");
        csr_write(12'h300, 64'h8);
        csr_write(12'h304, 64'h800);
        irq_ext_i = 1;
        commit(1, 0, 0, 64'h900, 64'h904, 0, 0, 0, 0);
        irq_ext_i = 0;
        // asynchronous reset while flushing
        commit_valid_i = 1; ecall_i = 1;
        @(negedge clk);
        commit_valid_i = 0; ecall_i = 0;
        check("abort_flush_pre", 64'(flush_o), 64'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check("abort_flush", 64'(flush_o), 64'd0);
        check("abort_busy", 64'(trap_busy_o), 64'd0);
        csr_check(12'h305, "abort_mtvec");
        csr_check(12'h342, "abort_mcause");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("abort_no_redirect", 64'(redirect_valid_o), 64'd0);
        for (int i = 0; i < 200; i++) begin
            int r;
            irq_sw_i = 1'($urandom_range(0, 1));
            irq_tm_i = 1'($urandom_range(0, 1));
            irq_ext_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) csr_write(addrs[$urandom_range(0, 6)], rnd64());
            r = $urandom_range(0, 9);
            commit($urandom_range(0, 3) != 0, r < 3, r >= 3 && r < 6, rnd64() & ~64'd3, rnd64() & ~64'd3,
                   $urandom_range(0, 4) == 0, addrs[$urandom_range(0, 6)], rnd64(), -1);
            csr_check(addrs[$urandom_range(0, 6)], "rand_csr");
        end
        @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
